// File: rtl/quat_norm_seed.sv
// Squared-norm front end of the fast inverse square root: x = sum(qi^2) with one
// shared multiplier, then x/2 and a power-of-two seed y0 ~ 1/sqrt(x).
module quat_norm_seed #(
    parameter int unsigned INT_WIDTH   = 12,
    parameter int unsigned FRACT_WIDTH = 4
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 start,
    input  logic [INT_WIDTH+FRACT_WIDTH-1:0]     q0,
    input  logic [INT_WIDTH+FRACT_WIDTH-1:0]     q1,
    input  logic [INT_WIDTH+FRACT_WIDTH-1:0]     q2,
    input  logic [INT_WIDTH+FRACT_WIDTH-1:0]     q3,
    output logic                                 done,
    output logic [INT_WIDTH+FRACT_WIDTH-1:0]     x,
    output logic [INT_WIDTH+FRACT_WIDTH-1:0]     x_half,
    output logic [INT_WIDTH+FRACT_WIDTH-1:0]     y0,
    output logic                                 zero,
    output logic                                 sat
);

    localparam int unsigned W  = INT_WIDTH + FRACT_WIDTH;
    localparam int unsigned PW = 2 * W;
    localparam int unsigned AW = 2 * W + 2;
    localparam logic [W-1:0]  XMAX = {1'b0, {(W-1){1'b1}}};
    localparam logic [AW-1:0] HALF = AW'(1) << (FRACT_WIDTH - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SQUARE,
        S_NORM,
        S_SEED,
        S_DONE
    } state_t;

    state_t          state_q;
    logic [W-1:0]    qr_q [4];
    logic [AW-1:0]   acc_q;
    logic [1:0]      cnt_q;

    logic signed [PW-1:0] qext_c;
    logic signed [PW-1:0] sq_c;
    logic [AW-1:0]        r_c;
    logic                 over_c;

    // Square of the captured component selected by the counter; always non-negative.
    assign qext_c = PW'($signed(qr_q[cnt_q]));
    assign sq_c   = qext_c * qext_c;
    assign r_c    = (acc_q + HALF) >> FRACT_WIDTH;
    assign over_c = r_c > AW'(XMAX);

    // Seed 2^s with s = F - floor((msb(v) - F) / 2), clamped to the representable range.
    function automatic logic [W-1:0] seed_f(input logic [W-1:0] v);
        int p;
        int k;
        int s;
        p = 0;
        for (int i = 0; i < int'(W); i++) begin
            if (v[i]) p = i;
        end
        k = p - int'(FRACT_WIDTH);
        s = int'(FRACT_WIDTH) - (k >>> 1);
        if (v == '0)               seed_f = XMAX;
        else if (s < 0)            seed_f = W'(1);
        else if (s > int'(W) - 2)  seed_f = XMAX;
        else                       seed_f = W'(1) << s;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            done    <= 1'b0;
            x       <= '0;
            x_half  <= '0;
            y0      <= '0;
            zero    <= 1'b0;
            sat     <= 1'b0;
            acc_q   <= '0;
            cnt_q   <= '0;
            for (int i = 0; i < 4; i++) qr_q[i] <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        qr_q[0] <= q0;
                        qr_q[1] <= q1;
                        qr_q[2] <= q2;
                        qr_q[3] <= q3;
                        acc_q   <= '0;
                        cnt_q   <= '0;
                        state_q <= S_SQUARE;
                    end
                end
                S_SQUARE: begin
                    acc_q <= acc_q + AW'($unsigned(sq_c));
                    cnt_q <= cnt_q + 2'd1;
                    if (cnt_q == 2'd3) state_q <= S_NORM;
                end
                S_NORM: begin
                    x       <= over_c ? XMAX : r_c[W-1:0];
                    sat     <= over_c;
                    zero    <= ~over_c && (r_c == '0);
                    state_q <= S_SEED;
                end
                S_SEED: begin
                    x_half  <= x >> 1;
                    y0      <= seed_f(x);
                    done    <= 1'b1;
                    state_q <= S_DONE;
                end
                S_DONE: begin
                    // Level handshake: results stay up until the requester drops start.
                    if (!start) begin
                        done    <= 1'b0;
                        state_q <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_quat_norm_seed.sv
// Bench for quat_norm_seed: transaction-level reference model with a cycle-by-cycle
// comparison, directed spot values, handshake, reset-mid-operation and random operands.
module tb_quat_norm_seed;

    localparam int W = 16;
    localparam int F = 4;
    localparam longint XMAXL = 32767;

    typedef struct packed {
        logic [15:0] x;
        logic [15:0] xh;
        logic [15:0] y;
        logic        z;
        logic        s;
    } res_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] q0, q1, q2, q3;
    logic        done;
    logic [15:0] x, x_half, y0;
    logic        zero, sat;

    int n_cmp = 0;
    int n_bad = 0;
    bit cmp_en = 1'b0;

    // Model state: accepted-operation tracking and expected visible outputs.
    bit   m_busy = 1'b0;
    bit   m_done = 1'b0;
    int   m_cnt  = 0;
    res_t p_res;
    res_t e_res;

    quat_norm_seed #(.INT_WIDTH(12), .FRACT_WIDTH(4)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .q0     (q0),
        .q1     (q1),
        .q2     (q2),
        .q3     (q3),
        .done   (done),
        .x      (x),
        .x_half (x_half),
        .y0     (y0),
        .zero   (zero),
        .sat    (sat)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
        end
    endtask

    // Results straight from the arithmetic definition of the norm, rounding and seed.
    function automatic res_t model_calc(input logic [15:0] a, input logic [15:0] b,
                                        input logic [15:0] c, input logic [15:0] d);
        res_t   r;
        longint sum;
        longint rr;
        longint t;
        int     p, k, fl, s;
        logic [15:0] qv [4];
        qv[0] = a; qv[1] = b; qv[2] = c; qv[3] = d;
        sum = 0;
        for (int i = 0; i < 4; i++) begin
            t = longint'($signed(qv[i]));
            sum += t * t;
        end
        rr = (sum + (2 ** (F - 1))) / (2 ** F);
        r.s  = (rr > XMAXL);
        r.x  = r.s ? 16'h7FFF : rr[15:0];
        r.z  = (r.x == 16'd0);
        r.xh = r.x / 16'd2;
        if (r.z) begin
            r.y = 16'h7FFF;
        end else begin
            t = longint'(r.x);
            p = -1;
            while (t > 0) begin
                t = t / 2;
                p++;
            end
            k  = p - F;
            fl = (k >= 0) ? (k / 2) : -((1 - k) / 2);
            s  = F - fl;
            if (s < 0)          r.y = 16'd1;
            else if (s > W - 2) r.y = 16'h7FFF;
            else                r.y = 16'(1 << s);
        end
        return r;
    endfunction

    // Timing model: accept in idle, NORM-visible outputs 5 edges later, done 6 edges later.
    always @(posedge clk) begin
        if (rst) begin
            m_busy <= 1'b0;
            m_done <= 1'b0;
            m_cnt  <= 0;
            e_res  <= '0;
        end else if (m_busy) begin
            m_cnt <= m_cnt + 1;
            if (m_cnt == 4) begin
                e_res.x <= p_res.x;
                e_res.z <= p_res.z;
                e_res.s <= p_res.s;
            end
            if (m_cnt == 5) begin
                e_res.xh <= p_res.xh;
                e_res.y  <= p_res.y;
                m_done   <= 1'b1;
                m_busy   <= 1'b0;
            end
        end else if (m_done) begin
            if (!start) m_done <= 1'b0;
        end else if (start) begin
            p_res  <= model_calc(q0, q1, q2, q3);
            m_busy <= 1'b1;
            m_cnt  <= 0;
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("done",   32'(done),   32'(m_done));
            chk("x",      32'(x),      32'(e_res.x));
            chk("x_half", 32'(x_half), 32'(e_res.xh));
            chk("y0",     32'(y0),     32'(e_res.y));
            chk("zero",   32'(zero),   32'(e_res.z));
            chk("sat",    32'(sat),    32'(e_res.s));
        end
    end

    // One operation: raise start, scramble operands after acceptance, wait for done, release.
    task automatic do_op(input logic [15:0] a, input logic [15:0] b,
                         input logic [15:0] c, input logic [15:0] d);
        bit got;
        @(negedge clk);
        q0 = a; q1 = b; q2 = c; q3 = d;
        start = 1'b1;
        @(negedge clk);
        q0 = 16'($urandom); q1 = 16'($urandom); q2 = 16'($urandom); q3 = 16'($urandom);
        got = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (done) begin
                got = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!got) begin
            n_cmp++;
            n_bad++;
            $display("FAIL done_timeout: got no done expected done within 20 cycles");
        end
        start = 1'b0;
        @(negedge clk);
    endtask

    task automatic chk_out(input string nm, input logic [15:0] ex, input logic [15:0] exh,
                           input logic [15:0] ey, input logic ez, input logic es);
        chk({nm, "_x"},    32'(x),      32'(ex));
        chk({nm, "_xhalf"}, 32'(x_half), 32'(exh));
        chk({nm, "_y0"},   32'(y0),     32'(ey));
        chk({nm, "_zero"}, 32'(zero),   32'(ez));
        chk({nm, "_sat"},  32'(sat),    32'(es));
    endtask

    initial begin
        int          rises;
        logic        prev;
        logic [15:0] v [4];
        rst = 1'b1; start = 1'b0;
        q0 = '0; q1 = '0; q2 = '0; q3 = '0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        cmp_en = 1'b1;
        chk("rst_done", 32'(done), 32'd0);
        chk_out("rst", 16'd0, 16'd0, 16'd0, 1'b0, 1'b0);

        do_op(16'd16, 16'd0, 16'd0, 16'd0);
        chk_out("unit", 16'd16, 16'd8, 16'd16, 1'b0, 1'b0);
        do_op(16'd8, 16'hFFF8, 16'd8, 16'hFFF8);
        chk_out("half", 16'd16, 16'd8, 16'd16, 1'b0, 1'b0);
        do_op(16'hFFE0, 16'd0, 16'd0, 16'd0);
        chk_out("neg2", 16'd64, 16'd32, 16'd8, 1'b0, 1'b0);
        do_op(16'd4, 16'd0, 16'd0, 16'd0);
        chk_out("small", 16'd1, 16'd0, 16'd64, 1'b0, 1'b0);
        do_op(16'd0, 16'd0, 16'd0, 16'd0);
        chk_out("zero", 16'd0, 16'd0, 16'h7FFF, 1'b1, 1'b0);
        do_op(16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF);
        chk_out("sat", 16'h7FFF, 16'h3FFF, 16'd1, 1'b0, 1'b1);

        // start held high for 20 cycles gives exactly one operation
        @(negedge clk);
        q0 = 16'd16; q1 = '0; q2 = '0; q3 = '0;
        start = 1'b1;
        rises = 0;
        prev  = done;
        repeat (20) begin
            @(negedge clk);
            if (done && !prev) rises++;
            prev = done;
        end
        chk("hold_rises", 32'(rises), 32'd1);
        chk("hold_done", 32'(done), 32'd1);
        start = 1'b0;
        @(negedge clk);
        chk("drop_done", 32'(done), 32'd0);

        // reset during the third SQUARE cycle
        @(negedge clk);
        q0 = 16'hFFE0; q1 = 16'd8; q2 = '0; q3 = '0;
        start = 1'b1;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        start = 1'b0;
        chk("midrst_done", 32'(done), 32'd0);
        chk_out("midrst", 16'd0, 16'd0, 16'd0, 1'b0, 1'b0);
        do_op(16'd4, 16'd0, 16'd0, 16'd0);
        chk_out("after_rst", 16'd1, 16'd0, 16'd64, 1'b0, 1'b0);

        // random operands: full range and small magnitudes with random signs
        for (int n = 0; n < 200; n++) begin
            for (int i = 0; i < 4; i++) begin
                if (n % 2 == 0) begin
                    v[i] = 16'($urandom);
                end else begin
                    v[i] = 16'($urandom_range(0, 80));
                    if ($urandom_range(0, 1) == 1) v[i] = -v[i];
                end
            end
            do_op(v[0], v[1], v[2], v[3]);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        cmp_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
